// File: rtl/gpio_stream_pkg.sv
// Shared widths, unpacker state encoding and lane placement helper for the
// GPIO pad stream bridge.
package gpio_stream_pkg;

   localparam int BYTE_W     = 8;
   localparam int IN_WORD_W  = 32;
   localparam int OUT_WORD_W = 16;
   localparam int LANES      = IN_WORD_W / BYTE_W;

   typedef enum logic [1:0] {
      UNP_IDLE = 2'd0,
      UNP_HI   = 2'd1,
      UNP_LO   = 2'd2
   } unp_state_t;

   // Bit offset of byte lane idx inside the packed word. With msb_first the
   // first byte of a word lands in bits [31:24], i.e. offset (3-idx)*8.
   function automatic logic [4:0] lane_lsb(input logic [1:0] idx, input logic msb_first);
      lane_lsb = msb_first ? {~idx, 3'b000} : {idx, 3'b000};
   endfunction

endpackage

// File: rtl/sync_byte_fifo.sv
// Small synchronous FIFO with a registered ready (not-full) flag. The ready
// flag is computed from the occupancy after this edge's push/pop, so it never
// depends combinationally on the write/read strobes.
module sync_byte_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 9
) (
   input  logic         clock,
   input  logic         resetb,
   input  logic         i_push,
   input  logic [W-1:0] i_wdata,
   input  logic         i_pop,
   output logic [W-1:0] o_rdata,
   output logic         o_empty,
   output logic         o_ready
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;
   logic          r_ready;

   logic          w_push;
   logic          w_pop;
   logic [AW:0]   w_count_nxt;

   assign w_push      = i_push && r_ready;
   assign w_pop       = i_pop && (r_count != '0);
   assign w_count_nxt = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

   assign o_rdata = r_mem[r_rptr];
   assign o_empty = (r_count == '0);
   assign o_ready = r_ready;

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wptr] <= i_wdata;
   end

   // Pointers, occupancy and the registered ready flag.
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ready <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         r_count <= w_count_nxt;
         r_ready <= (w_count_nxt < (AW+1)'(DEPTH));
      end
   end

endmodule

// File: rtl/gpio_stream_bridge.sv
// Pad stream endpoint: packs inbound pad bytes four at a time into 32-bit
// stream beats and serialises 16-bit result beats into two pad bytes.
//
// Unpacker states
//   state    | meaning
//   UNP_IDLE | no result held, s_tready high
//   UNP_HI   | presenting the first pad byte of the held result
//   UNP_LO   | presenting the second pad byte, carries the frame-end flag
module gpio_stream_bridge
   import gpio_stream_pkg::*;
#(
   parameter int IN_DEPTH  = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                  clock,
   input  logic                  resetb,
   input  logic                  pad_in_valid,
   input  logic [BYTE_W-1:0]     pad_in_data,
   input  logic                  pad_in_last,
   output logic                  pad_in_ready,
   output logic [IN_WORD_W-1:0]  m_tdata,
   output logic                  m_tvalid,
   output logic                  m_tlast,
   input  logic                  m_tready,
   input  logic [OUT_WORD_W-1:0] s_tdata,
   input  logic                  s_tvalid,
   input  logic                  s_tlast,
   output logic                  s_tready,
   output logic [BYTE_W-1:0]     pad_out_data,
   output logic                  pad_out_valid,
   output logic                  pad_out_last,
   input  logic                  pad_out_ready,
   output logic                  err_partial,
   input  logic                  err_clr
);

   logic                 w_fifo_empty;
   logic [BYTE_W:0]      w_fifo_rdata;
   logic                 w_pop;
   logic                 w_pop_last;
   logic [IN_WORD_W-1:0] w_lane_word;
   logic [IN_WORD_W-1:0] w_acc_nxt;
   logic                 w_word_done;

   logic [1:0]           r_idx;
   logic [IN_WORD_W-1:0] r_acc;
   logic [IN_WORD_W-1:0] r_m_tdata;
   logic                 r_m_tvalid;
   logic                 r_m_tlast;
   logic                 r_err;

   sync_byte_fifo #(
      .DEPTH (IN_DEPTH),
      .W     (BYTE_W + 1)
   ) u_in_fifo (
      .clock   (clock),
      .resetb  (resetb),
      .i_push  (pad_in_valid),
      .i_wdata ({pad_in_last, pad_in_data}),
      .i_pop   (w_pop),
      .o_rdata (w_fifo_rdata),
      .o_empty (w_fifo_empty),
      .o_ready (pad_in_ready)
   );

   // A byte may leave the FIFO only if the output register has room this edge.
   assign w_pop       = !w_fifo_empty && (!r_m_tvalid || m_tready);
   assign w_pop_last  = w_fifo_rdata[BYTE_W];
   assign w_lane_word = {{(IN_WORD_W-BYTE_W){1'b0}}, w_fifo_rdata[BYTE_W-1:0]}
                        << lane_lsb(r_idx, MSB_FIRST);
   assign w_acc_nxt   = r_acc | w_lane_word;
   assign w_word_done = w_pop && ((r_idx == 2'd3) || w_pop_last);

   // Packer: accumulate lanes, hand a finished word to the output register.
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         r_idx      <= 2'd0;
         r_acc      <= '0;
         r_m_tdata  <= '0;
         r_m_tvalid <= 1'b0;
         r_m_tlast  <= 1'b0;
      end else begin
         if (r_m_tvalid && m_tready) r_m_tvalid <= 1'b0;
         if (w_word_done) begin
            r_m_tdata  <= w_acc_nxt;
            r_m_tlast  <= w_pop_last;
            r_m_tvalid <= 1'b1;
            r_idx      <= 2'd0;
            r_acc      <= '0;
         end else if (w_pop) begin
            r_acc <= w_acc_nxt;
            r_idx <= r_idx + 2'd1;
         end
      end
   end

   // Sticky short-frame flag; a new short frame wins over a clear.
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         r_err <= 1'b0;
      end else if (w_pop && w_pop_last && (r_idx != 2'd3)) begin
         r_err <= 1'b1;
      end else if (err_clr) begin
         r_err <= 1'b0;
      end
   end

   assign m_tdata     = r_m_tdata;
   assign m_tvalid    = r_m_tvalid;
   assign m_tlast     = r_m_tlast;
   assign err_partial = r_err;

   unp_state_t            r_state;
   unp_state_t            w_state_nxt;
   logic [OUT_WORD_W-1:0] r_word;
   logic                  r_last;
   logic                  w_s_tready;
   logic                  w_pad_valid;
   logic                  w_pad_last;
   logic [BYTE_W-1:0]     w_pad_data;
   logic [BYTE_W-1:0]     w_first_byte;
   logic [BYTE_W-1:0]     w_second_byte;

   assign w_first_byte  = MSB_FIRST ? r_word[15:8] : r_word[7:0];
   assign w_second_byte = MSB_FIRST ? r_word[7:0]  : r_word[15:8];

   // Unpacker state register and held result word.
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         r_state <= UNP_IDLE;
         r_word  <= '0;
         r_last  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (s_tvalid && w_s_tready) begin
            r_word <= s_tdata;
            r_last <= s_tlast;
         end
      end
   end

   // Unpacker next state and pad/stream outputs.
   always_comb begin
      w_state_nxt = r_state;
      w_s_tready  = 1'b0;
      w_pad_valid = 1'b0;
      w_pad_last  = 1'b0;
      w_pad_data  = '0;
      case (r_state)
         UNP_IDLE: begin
            w_s_tready = 1'b1;
            if (s_tvalid) w_state_nxt = UNP_HI;
         end
         UNP_HI: begin
            w_pad_valid = 1'b1;
            w_pad_data  = w_first_byte;
            if (pad_out_ready) w_state_nxt = UNP_LO;
         end
         UNP_LO: begin
            w_pad_valid = 1'b1;
            w_pad_data  = w_second_byte;
            w_pad_last  = r_last;
            if (pad_out_ready) begin
               w_s_tready  = 1'b1;
               w_state_nxt = s_tvalid ? UNP_HI : UNP_IDLE;
            end
         end
         default: w_state_nxt = UNP_IDLE;
      endcase
   end

   assign s_tready      = w_s_tready;
   assign pad_out_valid = w_pad_valid;
   assign pad_out_data  = w_pad_data;
   assign pad_out_last  = w_pad_last;

endmodule

// File: tb/tb_gpio_stream_bridge.sv
// Bench for gpio_stream_bridge: one MSB-first and one LSB-first instance share
// all stimulus; a queue-based reference model predicts words and pad bytes.
module tb_gpio_stream_bridge;

   localparam int IN_DEPTH = 4;
   // With m_tready held low the bridge absorbs one full word plus a full FIFO.
   localparam int ACCEPT_CAP = IN_DEPTH + 4;

   logic        clock = 1'b0;
   logic        resetb;
   logic        pad_in_valid;
   logic [7:0]  pad_in_data;
   logic        pad_in_last;
   logic        m_tready;
   logic [15:0] s_tdata;
   logic        s_tvalid;
   logic        s_tlast;
   logic        pad_out_ready;
   logic        err_clr;

   logic        pad_in_ready_m, m_tvalid_m, m_tlast_m, s_tready_m;
   logic        pad_out_valid_m, pad_out_last_m, err_partial_m;
   logic [31:0] m_tdata_m;
   logic [7:0]  pad_out_data_m;
   logic        pad_in_ready_l, m_tvalid_l, m_tlast_l, s_tready_l;
   logic        pad_out_valid_l, pad_out_last_l, err_partial_l;
   logic [31:0] m_tdata_l;
   logic [7:0]  pad_out_data_l;

   int n_checks = 0;
   int n_fail   = 0;

   logic [8:0]  in_q[$];
   logic [32:0] exp_m_q[$];
   logic [32:0] exp_l_q[$];
   logic [16:0] out_q[$];
   logic [8:0]  exp_bm_q[$];
   logic [8:0]  exp_bl_q[$];
   bit          err_model;

   always #5 clock = ~clock;

   gpio_stream_bridge #(.IN_DEPTH(IN_DEPTH), .MSB_FIRST(1'b1)) dut_m (
      .clock(clock), .resetb(resetb),
      .pad_in_valid(pad_in_valid), .pad_in_data(pad_in_data), .pad_in_last(pad_in_last),
      .pad_in_ready(pad_in_ready_m),
      .m_tdata(m_tdata_m), .m_tvalid(m_tvalid_m), .m_tlast(m_tlast_m), .m_tready(m_tready),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready_m),
      .pad_out_data(pad_out_data_m), .pad_out_valid(pad_out_valid_m),
      .pad_out_last(pad_out_last_m), .pad_out_ready(pad_out_ready),
      .err_partial(err_partial_m), .err_clr(err_clr)
   );

   gpio_stream_bridge #(.IN_DEPTH(IN_DEPTH), .MSB_FIRST(1'b0)) dut_l (
      .clock(clock), .resetb(resetb),
      .pad_in_valid(pad_in_valid), .pad_in_data(pad_in_data), .pad_in_last(pad_in_last),
      .pad_in_ready(pad_in_ready_l),
      .m_tdata(m_tdata_l), .m_tvalid(m_tvalid_l), .m_tlast(m_tlast_l), .m_tready(m_tready),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready_l),
      .pad_out_data(pad_out_data_l), .pad_out_valid(pad_out_valid_l),
      .pad_out_last(pad_out_last_l), .pad_out_ready(pad_out_ready),
      .err_partial(err_partial_l), .err_clr(err_clr)
   );

   // Reference: split the byte list into words of four or at a frame end.
   task automatic build_in_expect();
      int lane = 0;
      logic [31:0] wm = '0;
      logic [31:0] wl = '0;
      exp_m_q.delete();
      exp_l_q.delete();
      foreach (in_q[i]) begin
         wm = wm | (32'(in_q[i][7:0]) << (8 * (3 - lane)));
         wl = wl | (32'(in_q[i][7:0]) << (8 * lane));
         if (lane == 3 || in_q[i][8]) begin
            exp_m_q.push_back({in_q[i][8], wm});
            exp_l_q.push_back({in_q[i][8], wl});
            if (in_q[i][8] && lane != 3) err_model = 1'b1;
            lane = 0;
            wm = '0;
            wl = '0;
         end else begin
            lane++;
         end
      end
   endtask

   task automatic run_in(input string name, input int gap_pct, input int rdy_pct,
                         input int hold, input int max_cycles);
      int idx = 0;
      int cyc = 0;
      logic held = 1'b0;
      logic [31:0] held_m = '0;
      logic [32:0] em, el;
      build_in_expect();
      while ((idx < in_q.size() || exp_m_q.size() != 0) && cyc < max_cycles) begin
         @(posedge clock); #1;
         if (hold > 0 && cyc == hold) begin
            n_checks++;
            if (idx !== ACCEPT_CAP) begin
               n_fail++;
               $display("FAIL %s accepted_under_backpressure: got %0d exp %0d", name, idx, ACCEPT_CAP);
            end
            n_checks++;
            if (pad_in_ready_m !== 1'b0) begin
               n_fail++;
               $display("FAIL %s pad_in_ready_when_full: got %b exp 0", name, pad_in_ready_m);
            end
         end
         if (held) begin
            n_checks++;
            if (m_tdata_m !== held_m) begin
               n_fail++;
               $display("FAIL %s m_tdata_hold: got %h exp %h", name, m_tdata_m, held_m);
            end
         end
         if (idx < in_q.size() && $urandom_range(99) >= gap_pct) begin
            pad_in_valid = 1'b1;
            pad_in_last  = in_q[idx][8];
            pad_in_data  = in_q[idx][7:0];
         end else begin
            pad_in_valid = 1'b0;
            pad_in_last  = 1'($urandom);
            pad_in_data  = 8'($urandom);
         end
         m_tready = (cyc < hold) ? 1'b0 : ($urandom_range(99) < rdy_pct);
         #1;
         held   = m_tvalid_m && !m_tready;
         held_m = m_tdata_m;
         if (pad_in_valid && pad_in_ready_m) idx++;
         if (m_tvalid_m && m_tready) begin
            n_checks++;
            if (exp_m_q.size() == 0) begin
               n_fail++;
               $display("FAIL %s unexpected_beat: got %h exp none", name, m_tdata_m);
            end else begin
               em = exp_m_q.pop_front();
               el = exp_l_q.pop_front();
               if ({m_tlast_m, m_tdata_m} !== em) begin
                  n_fail++;
                  $display("FAIL %s beat_msb: got %h exp %h", name, {m_tlast_m, m_tdata_m}, em);
               end
               n_checks++;
               if ({m_tlast_l, m_tdata_l} !== el) begin
                  n_fail++;
                  $display("FAIL %s beat_lsb: got %h exp %h", name, {m_tlast_l, m_tdata_l}, el);
               end
            end
         end
         cyc++;
      end
      pad_in_valid = 1'b0;
      m_tready     = 1'b1;
      n_checks++;
      if (cyc >= max_cycles) begin
         n_fail++;
         $display("FAIL %s timeout: got %0d cycles exp < %0d", name, cyc, max_cycles);
      end
   endtask

   task automatic run_out(input string name, input int vld_pct, input int rdy_mode,
                          input int max_cycles, output int cyc);
      int sent = 0;
      int pending;
      logic [15:0] d;
      cyc = 0;
      exp_bm_q.delete();
      exp_bl_q.delete();
      while ((sent < out_q.size() || exp_bm_q.size() != 0) && cyc < max_cycles) begin
         @(posedge clock); #1;
         if (sent < out_q.size() && $urandom_range(99) < vld_pct) begin
            s_tvalid = 1'b1;
            s_tlast  = out_q[sent][16];
            s_tdata  = out_q[sent][15:0];
         end else begin
            s_tvalid = 1'b0;
            s_tlast  = 1'($urandom);
            s_tdata  = 16'($urandom);
         end
         case (rdy_mode)
            0:       pad_out_ready = 1'b1;
            1:       pad_out_ready = (cyc % 2 == 0);
            default: pad_out_ready = 1'($urandom_range(1));
         endcase
         #1;
         pending = exp_bm_q.size();
         n_checks++;
         if (pad_out_valid_m !== (pending != 0)) begin
            n_fail++;
            $display("FAIL %s pad_out_valid: got %b exp %b", name, pad_out_valid_m, pending != 0);
         end
         if (pending == 2) begin
            n_checks++;
            if (s_tready_m !== 1'b0) begin
               n_fail++;
               $display("FAIL %s s_tready_in_first_byte: got %b exp 0", name, s_tready_m);
            end
         end
         if (pending > 0) begin
            n_checks++;
            if ({pad_out_last_m, pad_out_data_m} !== exp_bm_q[0]) begin
               n_fail++;
               $display("FAIL %s pad_byte_msb: got %h exp %h", name, {pad_out_last_m, pad_out_data_m}, exp_bm_q[0]);
            end
            n_checks++;
            if ({pad_out_last_l, pad_out_data_l} !== exp_bl_q[0]) begin
               n_fail++;
               $display("FAIL %s pad_byte_lsb: got %h exp %h", name, {pad_out_last_l, pad_out_data_l}, exp_bl_q[0]);
            end
            if (pad_out_valid_m && pad_out_ready) begin
               void'(exp_bm_q.pop_front());
               void'(exp_bl_q.pop_front());
            end
         end
         if (s_tvalid && s_tready_m) begin
            d = s_tdata;
            exp_bm_q.push_back({1'b0, d[15:8]});
            exp_bm_q.push_back({s_tlast, d[7:0]});
            exp_bl_q.push_back({1'b0, d[7:0]});
            exp_bl_q.push_back({s_tlast, d[15:8]});
            sent++;
         end
         cyc++;
      end
      s_tvalid = 1'b0;
      n_checks++;
      if (cyc >= max_cycles) begin
         n_fail++;
         $display("FAIL %s timeout: got %0d cycles exp < %0d", name, cyc, max_cycles);
      end
   endtask

   task automatic test_reset();
      resetb = 1'b0;
      pad_in_valid = 1'b0; pad_in_data = '0; pad_in_last = 1'b0;
      m_tready = 1'b1; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
      pad_out_ready = 1'b1; err_clr = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      n_checks++;
      if ({pad_in_ready_m, m_tvalid_m, m_tlast_m, m_tdata_m, s_tready_m, pad_out_valid_m,
           pad_out_data_m, pad_out_last_m, err_partial_m} !== {3'b000, 32'h0, 2'b10, 8'h00, 2'b00}) begin
         n_fail++;
         $display("FAIL reset_values_msb: got rdy=%b mv=%b ml=%b md=%h sr=%b pv=%b pd=%h pl=%b err=%b exp s_tready=1 rest 0",
                  pad_in_ready_m, m_tvalid_m, m_tlast_m, m_tdata_m, s_tready_m, pad_out_valid_m,
                  pad_out_data_m, pad_out_last_m, err_partial_m);
      end
      n_checks++;
      if ({pad_in_ready_l, m_tvalid_l, m_tdata_l, s_tready_l, pad_out_valid_l, err_partial_l}
          !== {2'b00, 32'h0, 3'b100}) begin
         n_fail++;
         $display("FAIL reset_values_lsb: got rdy=%b mv=%b md=%h sr=%b pv=%b err=%b exp s_tready=1 rest 0",
                  pad_in_ready_l, m_tvalid_l, m_tdata_l, s_tready_l, pad_out_valid_l, err_partial_l);
      end
      resetb = 1'b1;
      #1;
      n_checks++;
      if (pad_in_ready_m !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_before_first_edge: got %b exp 0", pad_in_ready_m);
      end
      @(posedge clock); #1;
      n_checks++;
      if (pad_in_ready_m !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_after_first_edge: got %b exp 1", pad_in_ready_m);
      end
   endtask

   task automatic test_pack_basic();
      in_q = '{9'h000, 9'h001, 9'h002, 9'h003};
      run_in("pack_basic", 0, 100, 0, 50);
      n_checks++;
      if (err_partial_m !== 1'b0) begin
         n_fail++;
         $display("FAIL pack_basic err_partial: got %b exp 0", err_partial_m);
      end
   endtask

   task automatic test_partial();
      err_model = 1'b0;
      in_q = '{9'h0AA, 9'h1BB};
      run_in("partial", 0, 100, 0, 50);
      @(posedge clock); #1;
      n_checks++;
      if ({err_partial_m, err_partial_l} !== {err_model, err_model}) begin
         n_fail++;
         $display("FAIL partial err_set: got %b%b exp %b%b", err_partial_m, err_partial_l, err_model, err_model);
      end
      err_clr = 1'b1;
      @(posedge clock); #1;
      err_clr = 1'b0;
      n_checks++;
      if (err_partial_m !== 1'b0) begin
         n_fail++;
         $display("FAIL partial err_clr: got %b exp 0", err_partial_m);
      end
   endtask

   task automatic test_backpressure();
      in_q.delete();
      for (int i = 0; i < 12; i++) in_q.push_back({1'b0, 8'(8'h10 + i)});
      run_in("backpressure", 0, 100, 20, 200);
   endtask

   task automatic test_random_in();
      logic [7:0] b;
      err_model = 1'b0;
      in_q.delete();
      for (int i = 0; i < 60; i++) begin
         b = 8'($urandom);
         in_q.push_back({(i == 59) || ($urandom_range(99) < 15), b});
      end
      run_in("random_in", 30, 70, 0, 2000);
      @(posedge clock); #1;
      n_checks++;
      if (err_partial_m !== err_model) begin
         n_fail++;
         $display("FAIL random_in err_partial: got %b exp %b", err_partial_m, err_model);
      end
   endtask

   task automatic test_unpack_directed();
      int cyc;
      out_q = '{17'h1_1234};
      run_out("unpack_1234", 100, 0, 20, cyc);
      n_checks++;
      if (cyc !== 3) begin
         n_fail++;
         $display("FAIL unpack_1234 cycles: got %0d exp 3", cyc);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      out_q.delete();
      for (int i = 0; i < 8; i++) out_q.push_back({(i == 7), 16'($urandom)});
      run_out("back_to_back", 100, 0, 60, cyc);
      n_checks++;
      if (cyc !== 17) begin
         n_fail++;
         $display("FAIL back_to_back cycles: got %0d exp 17", cyc);
      end
   endtask

   task automatic test_toggle_ready();
      int cyc;
      out_q.delete();
      for (int i = 0; i < 8; i++) out_q.push_back({1'($urandom), 16'($urandom)});
      run_out("toggle_ready", 100, 1, 100, cyc);
   endtask

   task automatic test_random_out();
      int cyc;
      out_q.delete();
      for (int i = 0; i < 12; i++) out_q.push_back({1'($urandom), 16'($urandom)});
      run_out("random_out", 60, 2, 300, cyc);
   endtask

   task automatic test_reset_mid();
      in_q = '{9'h011, 9'h022};
      run_in("mid_prep", 0, 100, 0, 20);
      repeat (3) @(posedge clock);
      #1;
      s_tvalid = 1'b1; s_tdata = 16'hBEEF; s_tlast = 1'b1; pad_out_ready = 1'b0;
      @(posedge clock); #1;
      s_tvalid = 1'b0;
      #1;
      n_checks++;
      if (pad_out_valid_m !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_prep pad_out_valid: got %b exp 1", pad_out_valid_m);
      end
      resetb = 1'b0;
      #1;
      n_checks++;
      if ({pad_in_ready_m, m_tvalid_m, m_tlast_m, m_tdata_m, s_tready_m, pad_out_valid_m,
           pad_out_data_m, pad_out_last_m, err_partial_m} !== {3'b000, 32'h0, 2'b10, 8'h00, 2'b00}) begin
         n_fail++;
         $display("FAIL reset_mid_values: got rdy=%b mv=%b md=%h sr=%b pv=%b pd=%h pl=%b err=%b exp s_tready=1 rest 0",
                  pad_in_ready_m, m_tvalid_m, m_tdata_m, s_tready_m, pad_out_valid_m,
                  pad_out_data_m, pad_out_last_m, err_partial_m);
      end
      @(posedge clock); #1;
      resetb = 1'b1;
      pad_out_ready = 1'b1;
      @(posedge clock); #1;
      in_q = '{9'h040, 9'h041, 9'h042, 9'h043};
      run_in("after_reset", 0, 100, 0, 50);
   endtask

   initial begin
      test_reset();
      test_pack_basic();
      test_partial();
      test_backpressure();
      test_random_in();
      test_unpack_directed();
      test_back_to_back();
      test_toggle_ready();
      test_random_out();
      test_reset_mid();
      repeat (2) @(posedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gpio_stream_bridge.md
# gpio_stream_bridge

On-chip endpoint of the byte-wide pad stream protocol on the user-project GPIOs. Inbound: receives 8-bit bytes with valid/ready/last from the pads and packs groups of four into 32-bit AXI4-Stream beats for the HyperSpace input. Outbound: takes 16-bit AXI4-Stream beats from the HyperSpace output and serialises each as two pad bytes. Sits between the mprj_io pad mapping and the HyperSpace stream ports in the user project wrapper.

## Interface
- IN_DEPTH, 4: inbound byte FIFO depth (power of 2, ≥2)
- MSB_FIRST, 1: 1 = first pad byte maps to the most significant byte (both directions); 0 = least significant
- clock  in  1  sole clock
- resetb  in  1  reset, asynchronous, active-low
- pad_in_valid  in  1  inbound byte valid (mprj_io[1])
- pad_in_data  in  8  inbound byte (mprj_io[9:2])
- pad_in_last  in  1  inbound frame end (mprj_io[10])
- pad_in_ready  out  1  inbound ready (mprj_io[0]), registered
- m_tdata  out  32  packed word to HyperSpace
- m_tvalid  out  1  packed word valid
- m_tlast  out  1  packed word ends frame
- m_tready  in  1  HyperSpace accepts
- s_tdata  in  16  result word from HyperSpace
- s_tvalid  in  1  result valid
- s_tlast  in  1  result ends frame
- s_tready  out  1  bridge accepts result
- pad_out_data  out  8  outbound byte (mprj_io[20:13])
- pad_out_valid  out  1  outbound valid (mprj_io[12])
- pad_out_last  out  1  outbound frame end (mprj_io[21])
- pad_out_ready  in  1  outbound ready (mprj_io[11])
- err_partial  out  1  sticky: a frame ended on a non-word boundary
- err_clr  in  1  synchronous clear of err_partial

## Operation
- All transfers occur on a rising clock edge where valid and ready are both high.
- Inbound FIFO: IN_DEPTH entries of {last, data}. pad_in_ready is a flop: next value = (occupancy after this edge's push/pop) < IN_DEPTH. No combinational path from any input to pad_in_ready.
- Packer: 2-bit byte index idx (0..3) plus a 32-bit accumulator. Pops one byte per cycle when FIFO non-empty and the output register is empty or being drained this cycle. The byte goes to lane idx (MSB_FIRST: lane 0 = bits [31:24]).
- On popping a byte with idx==3, or with last=1: the word moves to the output register, m_tvalid=1, m_tlast=last, idx returns to 0, accumulator clears.
- Early last (idx<3): unfilled lanes are zero, m_tlast=1, err_partial set.
- m_tdata/m_tlast are held stable while m_tvalid && !m_tready.
- Unpacker states IDLE, HI, LO. IDLE: s_tready=1; on accept latch word+last → HI. HI: pad_out_data = upper byte (MSB_FIRST), pad_out_last=0; on pad transfer → LO. LO: lower byte, pad_out_last = latched last; on pad transfer, s_tready is high in that same cycle; a new accept → HI, otherwise → IDLE.
- s_tready = (state==IDLE) || (state==LO && pad_out_ready). pad_out_valid = (state!=IDLE).
- err_partial: set has priority over err_clr in the same cycle.

## Timing
- Reset values: pad_in_ready=0, m_tvalid=0, m_tlast=0, m_tdata=0, s_tready=1 (IDLE), pad_out_valid=0, pad_out_data=0, pad_out_last=0, err_partial=0; FIFO empty, idx=0.
- pad_in_ready rises on the first edge after resetb deasserts.
- Inbound latency: 1 cycle from the pad push to FIFO visibility, plus 1 cycle from the 4th byte pop to m_tvalid. The 4th pad byte is therefore visible as m_tvalid 2 edges later. Sustained throughput is 1 byte/cycle when m_tready=1.
- Outbound: byte HI appears the cycle after s_tvalid accept. Sustained throughput is 2 bytes per s beat with no bubbles when pad_out_ready=1.
- Reset assertion mid-frame discards the FIFO, the partial word and the unpacker state immediately. It does not set err_partial.
- FIFO full with a simultaneous pop: pad_in_ready stays high.

## Structure
- gpio_stream_pkg: byte width (8), in word width (32), out word width (16), unpacker state enum, lane-index helper.
- Sub-module sync_byte_fifo (registered full flag, depth parameter), instantiated once for the inbound path. Packer and unpacker stay inline.

## Test plan
- Pads push 00,01,02,03 back-to-back, m_tready=1 → one beat m_tdata=0x00010203, m_tlast=0 (MSB_FIRST=1); with MSB_FIRST=0 → 0x03020100.
- Push AA,BB with last on BB → m_tdata=0xAABB0000, m_tlast=1, err_partial=1; err_clr pulse → 0.
- Hold m_tready=0, push 12 bytes → pad_in_ready drops after FIFO fills; release → three words in order, no loss or duplication.
- s_tdata=0x1234, s_tlast=1, pad_out_ready=1 → pad bytes 12 then 34 on consecutive cycles, pad_out_last only on 34; back-to-back beats show no idle cycle.
- Toggle pad_out_ready 1/0 per cycle over 8 beats → byte order preserved, s_tready never high while state==HI.
- Assert resetb low mid-word (idx=2) → all outputs return to reset values; a following frame packs from lane 0.
